// File: rtl/mtp_access_arbiter.sv
// mtp_access_arbiter
// Shares the single MTP interface engine (IE) between the power-up init loader,
// the parameter loader and the OCU (read and write). Fixed priority
// init > OCU_wr > OCU_rd > par, decided only in IDLE, no preemption.
// Optional job watchdog: define MTP_TIMEOUT_EN.
module mtp_access_arbiter #(
  parameter int PULSE_CYC = 2,
  parameter int TO_CYC    = 4095
) (
  input  logic        clk_1_92m,
  input  logic        rst_n,
  input  logic        req_init,
  input  logic        req_par,
  input  logic        req_OCU_rd,
  input  logic        req_OCU_wr,
  input  logic [5:0]  ptr_init,
  input  logic [5:0]  len_init,
  input  logic [5:0]  ptr_par,
  input  logic [5:0]  len_par,
  input  logic [5:0]  ptr_OCU,
  input  logic [5:0]  len_OCU,
  input  logic        word_done_ie,
  input  logic        job_done_ie,
  input  logic [15:0] mtp_data_ie,
  output logic        ie_en,
  output logic [5:0]  pointer_init,
  output logic [5:0]  length_init,
  output logic [5:0]  pointer_par,
  output logic [5:0]  length_par,
  output logic [5:0]  pointer_OCU,
  output logic [5:0]  length_OCU,
  output logic        read_en_init,
  output logic        read_en_par,
  output logic        read_en_OCU,
  output logic        wr_pulse,
  output logic        gnt_init,
  output logic        gnt_par,
  output logic        gnt_OCU,
  output logic        done_init,
  output logic        done_par,
  output logic        done_OCU,
  output logic        word_vld,
  output logic [15:0] rd_word,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, ARM, ISSUE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_PAR, SRC_OCU_RD, SRC_OCU_WR} src_t;

  if (PULSE_CYC < 1 || PULSE_CYC > 7 || TO_CYC < 2 || TO_CYC > 4095) begin : g_bad_params
    $error("mtp_access_arbiter: PULSE_CYC or TO_CYC out of range");
  end

  state_t      state, state_nxt;
  src_t        src, win_src;
  logic        win;
  logic [5:0]  win_ptr, win_len;
  logic [5:0]  len_q;
  logic [2:0]  pulse_cnt;
  logic [6:0]  word_cnt, words_at_jd;
  logic        err_flag;
  logic [1:0]  wd_sync, jd_sync;
  logic        wd_prev, jd_prev;
  logic        wd_rise, jd_rise;
  logic        is_read, in_job;
  logic        timeout_hit;

  assign wd_rise     = wd_sync[1] & ~wd_prev;
  assign jd_rise     = jd_sync[1] & ~jd_prev;
  assign is_read     = (src != SRC_OCU_WR);
  assign in_job      = (state == ISSUE) || (state == BUSY);
  assign words_at_jd = word_cnt + {6'd0, wd_rise};

  // Bring the IE's asynchronous done strobes into clk_1_92m and edge-detect them
  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      wd_sync <= 2'b00;
      jd_sync <= 2'b00;
      wd_prev <= 1'b0;
      jd_prev <= 1'b0;
    end else begin
      wd_sync <= {wd_sync[0], word_done_ie};
      jd_sync <= {jd_sync[0], job_done_ie};
      wd_prev <= wd_sync[1];
      jd_prev <= jd_sync[1];
    end
  end

  // Fixed-priority pick of the winning requester; writes always move one word
  always_comb begin
    win     = 1'b1;
    win_src = SRC_PAR;
    win_ptr = ptr_par;
    win_len = len_par;
    if (req_init) begin
      win_src = SRC_INIT;
      win_ptr = ptr_init;
      win_len = len_init;
    end else if (req_OCU_wr) begin
      win_src = SRC_OCU_WR;
      win_ptr = ptr_OCU;
      win_len = 6'd1;
    end else if (req_OCU_rd) begin
      win_src = SRC_OCU_RD;
      win_ptr = ptr_OCU;
      win_len = len_OCU;
    end else if (!req_par) begin
      win = 1'b0;
    end
  end

`ifdef MTP_TIMEOUT_EN
  logic [11:0] to_cnt;

  // Job watchdog: ARM counts as cycle 0, so DONE lands TO_CYC cycles after ARM
  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n)            to_cnt <= 12'd0;
    else if (state == ARM) to_cnt <= 12'd0;
    else if (in_job)       to_cnt <= to_cnt + 12'd1;
  end

  assign timeout_hit = in_job && (to_cnt == 12'(TO_CYC - 2));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the IE/requester strobes decoded from state and owner
  always_comb begin
    state_nxt    = state;
    ie_en        = 1'b0;
    gnt_init     = 1'b0;
    gnt_par      = 1'b0;
    gnt_OCU      = 1'b0;
    read_en_init = 1'b0;
    read_en_par  = 1'b0;
    read_en_OCU  = 1'b0;
    wr_pulse     = 1'b0;
    done_init    = 1'b0;
    done_par     = 1'b0;
    done_OCU     = 1'b0;
    err          = 1'b0;
    if (state != IDLE) begin
      gnt_init = (src == SRC_INIT);
      gnt_par  = (src == SRC_PAR);
      gnt_OCU  = (src == SRC_OCU_RD) || (src == SRC_OCU_WR);
    end
    case (state)
      IDLE: begin
        if (win) state_nxt = (win_src != SRC_OCU_WR && win_len == 6'd0) ? DONE : ARM;
      end
      ARM: begin
        ie_en     = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        ie_en        = 1'b1;
        read_en_init = (src == SRC_INIT);
        read_en_par  = (src == SRC_PAR);
        read_en_OCU  = (src == SRC_OCU_RD);
        wr_pulse     = (src == SRC_OCU_WR);
        if (timeout_hit)                             state_nxt = DONE;
        else if (pulse_cnt == 3'(PULSE_CYC - 1))     state_nxt = BUSY;
      end
      BUSY: begin
        ie_en = 1'b1;
        if (jd_rise || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        done_init = (src == SRC_INIT);
        done_par  = (src == SRC_PAR);
        done_OCU  = (src == SRC_OCU_RD) || (src == SRC_OCU_WR);
        err       = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job context, IE pointer/length registers, word capture and error tracking
  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      src          <= SRC_INIT;
      len_q        <= 6'd0;
      pulse_cnt    <= 3'd0;
      word_cnt     <= 7'd0;
      err_flag     <= 1'b0;
      word_vld     <= 1'b0;
      rd_word      <= 16'h0000;
      pointer_init <= 6'h00;
      length_init  <= 6'h00;
      pointer_par  <= 6'h00;
      length_par   <= 6'h00;
      pointer_OCU  <= 6'h00;
      length_OCU   <= 6'h00;
    end else begin
      word_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (win) begin
            src      <= win_src;
            len_q    <= win_len;
            word_cnt <= 7'd0;
            err_flag <= 1'b0;
            case (win_src)
              SRC_INIT: begin pointer_init <= win_ptr; length_init <= win_len; end
              SRC_PAR:  begin pointer_par  <= win_ptr; length_par  <= win_len; end
              default:  begin pointer_OCU  <= win_ptr; length_OCU  <= win_len; end
            endcase
          end
        end
        ARM:     pulse_cnt <= 3'd0;
        ISSUE:   pulse_cnt <= pulse_cnt + 3'd1;
        default: ;
      endcase
      if (in_job && wd_rise && is_read) begin
        rd_word  <= mtp_data_ie;
        word_vld <= 1'b1;
        word_cnt <= word_cnt + 7'd1;
      end
      if (state == BUSY && jd_rise && is_read && words_at_jd != {1'b0, len_q})
        err_flag <= 1'b1;
      if (timeout_hit)
        err_flag <= 1'b1;
    end
  end

endmodule
